// File: rtl/clm_round_key_sequencer_if.sv
// Handshake bundle between the round-key sequencer and CLM key expansion.
interface clm_round_key_sequencer_if #(
    parameter int KW = 192
);
    logic [KW-1:0] ke_in;
    logic          ke_drdy_i;
    logic          ke_first_round;
    logic          ke_drdy_o;
    logic [KW-1:0] ke_out;

    modport master (
        output ke_in, ke_drdy_i, ke_first_round,
        input  ke_drdy_o, ke_out
    );

    modport slave (
        input  ke_in, ke_drdy_i, ke_first_round,
        output ke_drdy_o, ke_out
    );
endinterface

// File: rtl/clm_round_key_sequencer.sv
// Round-key sequencer fed by CLM key expansion; delivers round keys 0..NR on request.
// Optional CLM_RK_CACHE_EN keeps every delivered key for single-cycle replay after rewind.
module clm_round_key_sequencer #(
    parameter  int D  = 4,
    parameter  int NR = 10,
    localparam int KW = 16 * (8 + D)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [KW-1:0]            key_in,
    input  logic                     key_load,
    input  logic                     rk_req,
    input  logic                     rk_rewind,
    output logic [KW-1:0]            rk_out,
    output logic                     rk_valid,
    output logic [3:0]               rk_idx,
    output logic                     rk_last,
    output logic                     busy,
    clm_round_key_sequencer_if.master ke
);
    typedef enum logic [2:0] {IDLE, READY, START, WAIT, DRAIN} state_t;

    localparam logic [3:0] LAST = 4'(NR);

    state_t        state;
    logic [KW-1:0] cur_key;
    logic [KW-1:0] orig_key;
    logic [3:0]    idx;
    logic          served;
    logic          got;
    logic          drdy_i;
    logic          restart;
    logic          done_now;

    assign restart = key_load | (rk_rewind & (state != IDLE));

    // No expansion left outstanding after this edge, so a restart can land in READY.
    assign done_now = (state == IDLE) | (state == READY)
                    | ((state == WAIT) & (got | ke.ke_drdy_o))
                    | ((state == DRAIN) & ke.ke_drdy_o);

    assign busy              = (state == START) | (state == WAIT) | (state == DRAIN);
    assign ke.ke_in          = cur_key;
    assign ke.ke_drdy_i      = drdy_i;
    assign ke.ke_first_round = ((state == READY) | (state == START)) & (idx == 4'd0);

`ifdef CLM_RK_CACHE_EN
    logic [KW-1:0] cache [0:NR];
    logic          cache_full;
    logic          replay;

    always_ff @(posedge clk) begin
        if (rk_valid) cache[rk_idx] <= rk_out;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur_key  <= '0;
            orig_key <= '0;
            idx      <= '0;
            served   <= 1'b0;
            got      <= 1'b0;
            drdy_i   <= 1'b0;
            rk_out   <= '0;
            rk_valid <= 1'b0;
            rk_idx   <= '0;
            rk_last  <= 1'b0;
`ifdef CLM_RK_CACHE_EN
            cache_full <= 1'b0;
            replay     <= 1'b0;
`endif
        end else begin
            rk_valid <= 1'b0;
            drdy_i   <= 1'b0;
`ifdef CLM_RK_CACHE_EN
            if (rk_valid && rk_idx == LAST) cache_full <= 1'b1;
`endif
            if (restart) begin
                cur_key <= key_load ? key_in : orig_key;
                if (key_load) orig_key <= key_in;
                idx     <= '0;
                served  <= 1'b0;
                got     <= 1'b0;
                rk_last <= 1'b0;
                state   <= done_now ? READY : DRAIN;
`ifdef CLM_RK_CACHE_EN
                replay  <= !key_load && cache_full;
                if (key_load) cache_full <= 1'b0;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                    end
                    READY: begin
                        if (rk_req) begin
                            if (!served) begin
                                rk_valid <= 1'b1;
                                rk_out   <= cur_key;
                                rk_idx   <= idx;
                                rk_last  <= (idx == LAST);
                                served   <= 1'b1;
                            end else if (idx != LAST) begin
`ifdef CLM_RK_CACHE_EN
                                if (replay) begin
                                    rk_valid <= 1'b1;
                                    rk_out   <= cache[idx + 4'd1];
                                    rk_idx   <= idx + 4'd1;
                                    rk_last  <= ((idx + 4'd1) == LAST);
                                    idx      <= idx + 4'd1;
                                end else begin
                                    state  <= START;
                                    drdy_i <= 1'b1;
                                end
`else
                                state  <= START;
                                drdy_i <= 1'b1;
`endif
                            end
                        end
                    end
                    START: state <= WAIT;
                    WAIT: begin
                        if (got) begin
                            rk_valid <= 1'b1;
                            rk_out   <= cur_key;
                            rk_idx   <= idx;
                            rk_last  <= (idx == LAST);
                            served   <= 1'b1;
                            got      <= 1'b0;
                            state    <= READY;
                        end else if (ke.ke_drdy_o) begin
                            cur_key <= ke.ke_out;
                            idx     <= idx + 4'd1;
                            got     <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (ke.ke_drdy_o) state <= READY;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/clm_round_key_sequencer.md
Name: clm_round_key_sequencer

Overview:
- Control and storage stage directly downstream of the CLM key-expansion sub-module.
- Holds the current (transformed) cipher key and drives the key-expansion handshake one round at a time.
- Captures each expanded round key and presents round keys 0..NR to the cipher datapath on request.
- Supports rewind to round 0 for the next block without the datapath reloading the key.

Parameters:
- D, 4, extra CLM bits per byte; one key element is 8+D bits.
- NR, 10, number of cipher rounds; round keys 0..NR are produced.
- KW, 16*(8+D), derived width of a full round key (16 elements, row-major, element [0][0] in MSBs).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- key_in  in  KW  initial transformed key
- key_load  in  1  pulse; latch key_in as round key 0
- rk_req  in  1  pulse; request next round key
- rk_rewind  in  1  pulse; restart at round 0 with the same key
- rk_out  out  KW  round key
- rk_valid  out  1  one-cycle pulse, rk_out/rk_idx valid
- rk_idx  out  4  index of rk_out
- rk_last  out  1  high while rk_idx==NR after delivery
- busy  out  1  high in any state other than IDLE or READY
- ke_in  out  KW  key presented to key expansion (current key register)
- ke_drdy_i  out  1  one-cycle start pulse to key expansion
- ke_first_round  out  1  forces key-expansion rcon reset
- ke_drdy_o  in  1  key-expansion done pulse
- ke_out  in  KW  expanded key, valid in the ke_drdy_o cycle

Behaviour:
- Reset: all outputs 0; key, orig_key and idx registers 0; state IDLE.
- Registers:
  - cur_key drives ke_in and rk_out.
  - orig_key holds the loaded key.
  - idx counts 0..NR.
  - served flag: the round key at idx has already been delivered.
- States: IDLE, READY, START, WAIT, DRAIN.
- IDLE:
  - rk_req and rk_rewind are ignored.
  - key_load: cur_key and orig_key take key_in, idx=0, served=0, go to READY.
- READY:
  - ke_first_round = (idx==0).
  - rk_req with served==0: next cycle rk_valid=1 with rk_out=cur_key and rk_idx=idx (latency 1); then served=1.
  - rk_req with served==1 and idx<NR: go to START.
  - rk_req with idx==NR and served==1: ignored; rk_last stays high.
- START (1 cycle):
  - ke_drdy_i=1, ke_first_round=(idx==0); go to WAIT.
- WAIT:
  - On ke_drdy_o: cur_key takes ke_out and idx increments.
  - Next cycle: rk_valid pulse with the new key, served=1, go to READY.
  - Total latency from rk_req = 2 + key-expansion latency + 1 cycles.
- rk_rewind in READY: cur_key takes orig_key, idx=0, served=0, rk_last cleared.
- key_load in READY: same effect as rewind, but orig_key and cur_key take key_in.
- key_load or rk_rewind in START/WAIT:
  - The expansion cannot be aborted; registers update as for READY.
  - Go to DRAIN: wait for ke_drdy_o, discard ke_out, then READY. No rk_valid is produced.
- Simultaneous events:
  - key_load has priority over rk_rewind, which has priority over rk_req.
  - rk_req arriving while busy is dropped, not queued.
- ke_drdy_o outside WAIT/DRAIN is ignored.
- Async reset mid-expansion returns to IDLE immediately. Key expansion shares rst, so no drain is needed.

Optional Feature:
- Macro: CLM_RK_CACHE_EN.
- With the macro defined:
  - Add an NR+1 entry KW-bit cache, written at every rk_valid at address rk_idx.
  - cache_full is set when idx NR is written, and cleared by key_load or reset.
  - After rk_rewind with cache_full=1, every rk_req is served from the cache with latency 1. No ke_drdy_i is issued and busy stays 0.
  - ke_in still shows orig_key.
- Without the macro: no cache; every rewind re-expands through key expansion.

Test Plan:
- The bench uses a stub key expansion: ke_drdy_o asserts 3 cycles after ke_drdy_i, and ke_out = ke_in + 1.
- Reset and load, D=4 (KW=192):
  - Reset -> all outputs 0.
  - key_load with key_in=0x11...11, then rk_req -> rk_valid next cycle, rk_idx=0, rk_out=0x11...11, ke_first_round=1.
- Full schedule:
  - 11 rk_req, each issued after the previous rk_valid.
  - rk_idx 0..10, rk_out = key+idx, ke_first_round high only at the first ke_drdy_i, rk_last=1 after idx 10.
  - A 12th rk_req -> no rk_valid and no ke_drdy_i.
- Busy drop: rk_req issued in the cycle after START -> ignored; exactly one rk_valid (idx 1).
- Load during WAIT:
  - key_load key_in=0x22...22 two cycles after ke_drdy_i -> DRAIN, no rk_valid, busy until stub ke_drdy_o.
  - Then rk_req -> rk_idx=0, rk_out=0x22...22.
- Rewind after round 5 -> next rk_req returns idx 0 with orig_key; the following rk_req triggers ke_first_round=1.
- With CLM_RK_CACHE_EN:
  - After the full schedule, rewind and 11 rk_req -> keys identical to the first pass.
  - Each key arrives 1 cycle after its rk_req, and ke_drdy_i is never asserted.
